// File: rtl/par_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : par_serial_tx
//  Description : Parallel-to-serial symbol transmitter. Every WIDTH clocks
//                a new symbol is chosen (DATA word, IDLE filler or COM
//                marker) and shifted out one bit per clock, back to back.
//  Ports       : clk_32f    - serial bit clock, rising edge
//                reset_L    - synchronous active-low reset
//                active     - link active, sampled at symbol boundaries
//                data_in    - parallel word to send
//                in_valid   - data_in holds a word
//                in_ready   - word accepted this cycle (combinational)
//                out_serial - registered serial bit
//                sym_start  - registered, first bit of a symbol
//                sym_type   - registered symbol type 00=COM 01=IDLE 10=DATA
//  Revision    : 1.0 - initial release
// ============================================================================
module par_serial_tx #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] COM_SYM   = WIDTH'(8'hBC),
    parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(8'h7C),
    parameter int               LSB_FIRST = 0
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             active,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_serial,
    output logic             sym_start,
    output logic [1:0]       sym_type
);

    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [1:0]       c_TYPE_COM  = 2'b00;
    localparam logic [1:0]       c_TYPE_IDLE = 2'b01;
    localparam logic [1:0]       c_TYPE_DATA = 2'b10;

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0] shift_q,   shift_d;
    logic             serial_q,  serial_d;
    logic             start_q,   start_d;
    logic [1:0]       type_q,    type_d;

    logic             w_boundary;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sym;
    logic [1:0]       w_type;
    logic             w_first;
    logic [WIDTH-2:0] w_rest;
    logic             w_next;
    logic [WIDTH-2:0] w_shifted;

    // Reset is handled with priority in the register block, so here a
    // boundary is simply the start of a symbol period.
    assign w_boundary = (bit_cnt_q == '0);
    assign in_ready   = w_boundary && active && reset_L;
    assign w_xfer     = in_valid && in_ready;

    // Fixed-priority symbol selection: accepted data, then filler, then COM.
    always_comb begin
        w_sym  = COM_SYM;
        w_type = c_TYPE_COM;
        if (w_xfer) begin
            w_sym  = data_in;
            w_type = c_TYPE_DATA;
        end else if (active) begin
            w_sym  = IDLE_SYM;
            w_type = c_TYPE_IDLE;
        end
    end

    // The first bit goes straight to the output register; the shift register
    // only ever holds the remaining WIDTH-1 bits, aligned so the next bit
    // to send is always at the same end.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_first   = w_sym[0];
            assign w_rest    = w_sym[WIDTH-1:1];
            assign w_next    = shift_q[0];
            assign w_shifted = shift_q >> 1;
        end else begin : g_msb_first
            assign w_first   = w_sym[WIDTH-1];
            assign w_rest    = w_sym[WIDTH-2:0];
            assign w_next    = shift_q[WIDTH-2];
            assign w_shifted = shift_q << 1;
        end
    endgenerate

    always_comb begin
        // Explicit wrap so non-power-of-two widths stay in 0..WIDTH-1.
        bit_cnt_d = (bit_cnt_q == c_CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
        serial_d  = w_next;
        start_d   = 1'b0;
        type_d    = type_q;
        shift_d   = w_shifted;
        if (w_boundary) begin
            serial_d = w_first;
            start_d  = 1'b1;
            type_d   = w_type;
            shift_d  = w_rest;
        end
    end

    // Reset discards any symbol in flight; the first edge after release
    // sees bit_cnt_q == 0 and therefore starts a fresh symbol.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b0;
            start_q   <= 1'b0;
            type_q    <= c_TYPE_COM;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            start_q   <= start_d;
            type_q    <= type_d;
        end
    end

    assign out_serial = serial_q;
    assign sym_start  = start_q;
    assign sym_type   = type_q;

endmodule
`default_nettype wire

// File: doc/par_serial_tx.md
PAR_SERIAL_TX -- requirements
Module: par_serial_tx

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning symbol width in bits; legal range 2 to 32.
REQ-002 The block SHALL have parameter COM_SYM, default 8'hBC (WIDTH bits), meaning the symbol sent while the link is inactive.
REQ-003 The block SHALL have parameter IDLE_SYM, default 8'h7C (WIDTH bits), meaning the filler symbol sent while the link is active and no data is offered.
REQ-004 The block SHALL have parameter LSB_FIRST, default 0, meaning serial bit order: 0 for MSB first, 1 for LSB first.

Interface
REQ-005 The block SHALL have port clk_32f, input, 1 bit: serial bit clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_L, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port active, input, 1 bit: link active; it is sampled only at symbol boundaries.
REQ-008 The block SHALL have port data_in, input, WIDTH bits: parallel data word.
REQ-009 The block SHALL have port in_valid, input, 1 bit: data_in holds a word to send.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-011 The block SHALL have port out_serial, output, 1 bit: registered serial bit stream.
REQ-012 The block SHALL have port sym_start, output, 1 bit: registered; high while out_serial carries the first bit of a symbol.
REQ-013 The block SHALL have port sym_type, output, 2 bits: registered type of the symbol on out_serial: 00 = COM, 01 = IDLE, 10 = DATA.

Function
REQ-014 An internal bit counter bit_cnt SHALL be $clog2(WIDTH) bits wide, count 0..WIDTH-1, and wrap to 0 after WIDTH-1, including for non-power-of-two WIDTH.
REQ-015 A symbol boundary SHALL be any clock edge where bit_cnt==0 and reset_L==1.
REQ-016 in_ready SHALL be combinational and equal (bit_cnt==0) AND active AND reset_L.
REQ-017 A transfer SHALL occur when in_valid and in_ready are both high; data_in is accepted and the word is not held past that cycle.
REQ-018 At a boundary, symbol selection SHALL use fixed priority: transfer gives DATA (data_in); else active==1 gives IDLE_SYM; else COM_SYM.
REQ-019 At a boundary, out_serial SHALL take the first bit of the selected symbol (MSB, or LSB if LSB_FIRST=1), sym_start SHALL go to 1, sym_type SHALL take the selected type, and the remaining WIDTH-1 bits SHALL be loaded into the shift register.
REQ-020 On each non-boundary edge, out_serial SHALL take the next bit from the shift register, sym_start SHALL go to 0, and sym_type SHALL hold its value.
REQ-021 Latency: for a word accepted at edge N, its first bit SHALL be valid after edge N and its last bit after edge N+WIDTH-1; symbols SHALL be back-to-back with no gap cycles.
REQ-022 Changes on active, in_valid or data_in between boundaries SHALL NOT affect the symbol in flight.
REQ-023 When in_valid is high and active is low, in_ready SHALL stay 0, COM_SYM SHALL be sent, and the word SHALL remain pending at the source.
REQ-024 When in_valid is low at a boundary with active high, IDLE_SYM SHALL be sent; there is no underrun error.

Reset
REQ-025 While reset_L==0 at a clock edge, the block SHALL set out_serial=0, sym_start=0, sym_type=00, bit_cnt=0 and shift register=0; in_ready SHALL be 0.
REQ-026 Reset asserted mid-symbol SHALL abandon the symbol in flight with no completion of its remaining bits.
REQ-027 The first edge with reset_L==1 SHALL be a symbol boundary.

Verification (WIDTH=8, defaults)
REQ-028 Reset release with active=0 -> out_serial repeats 1,0,1,1,1,1,0,0 (0xBC) and sym_start is high on every 8th bit.
REQ-029 active=1, in_valid=0 -> 0,1,1,1,1,1,0,0 (0x7C) repeated, with sym_type=01.
REQ-030 active=1, in_valid=1 with data 0xA5 then 0x3C -> in_ready pulses one cycle per 8; serial stream 10100101 00111100 back-to-back with sym_type=10.
REQ-031 LSB_FIRST=1, data 0x01 -> stream 1,0,0,0,0,0,0,0.
REQ-032 active toggled at bit 3 of a COM symbol -> COM symbol completes unchanged and the switch takes effect at the next boundary; reset_L low at bit 4 -> out_serial=0 on the next edge and bit_cnt restarts at 0.
REQ-033 WIDTH=10 -> bit_cnt wraps 9->0 and sym_start period is 10 cycles.
